// File: rtl/fp_flt.sv
// Registered IEEE-754 less-than comparator (FLT): lt = A < B, nv on any NaN operand.
// One-cycle latency, one compare per cycle, no backpressure.

module fp_flt_cls #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0]   op_i,
    output logic                   sign_o,
    output logic [EXP_W+MAN_W-1:0] mag_o,
    output logic                   nan_o,
    output logic                   zero_o
);
    logic [EXP_W-1:0] exp_w;
    logic [MAN_W-1:0] man_w;

    assign sign_o = op_i[EXP_W+MAN_W];
    assign exp_w  = op_i[EXP_W+MAN_W-1:MAN_W];
    assign man_w  = op_i[MAN_W-1:0];
    assign mag_o  = op_i[EXP_W+MAN_W-1:0];
    assign nan_o  = (&exp_w) && (|man_w);
    assign zero_o = ~|mag_o;
endmodule

module fp_flt #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [EXP_W+MAN_W:0] fp_a,
    input  logic [EXP_W+MAN_W:0] fp_b,
    output logic                 out_valid,
    output logic                 lt,
    output logic                 nv
);
    localparam int MW = EXP_W + MAN_W;

    logic          sa, sb, nan_a, nan_b, zero_a, zero_b;
    logic [MW-1:0] mag_a, mag_b;
    logic          lt_d, nv_d;
    logic          vld_q, lt_q, nv_q;

    fp_flt_cls #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op_i(fp_a), .sign_o(sa), .mag_o(mag_a), .nan_o(nan_a), .zero_o(zero_a)
    );
    fp_flt_cls #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op_i(fp_b), .sign_o(sb), .mag_o(mag_b), .nan_o(nan_b), .zero_o(zero_b)
    );

    // Sign-magnitude ordering: differing signs decide outright, equal signs
    // compare magnitudes with the sense flipped for negatives.
    always_comb begin
        nv_d = nan_a | nan_b;
        lt_d = 1'b0;
        if (nv_d || (zero_a && zero_b))
            lt_d = 1'b0;
        else if (sa != sb)
            lt_d = sa;
        else if (!sa)
            lt_d = (mag_a < mag_b);
        else
            lt_d = (mag_a > mag_b);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            lt_q  <= 1'b0;
            nv_q  <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                lt_q <= lt_d;
                nv_q <= nv_d;
            end
        end
    end

    assign out_valid = vld_q;
    assign lt        = lt_q;
    assign nv        = nv_q;
endmodule

// File: tb/tb_fp_flt.sv
// Self-checking bench for fp_flt: directed table, randomized model compare,
// streaming, hold and asynchronous reset behaviour.

module tb_fp_flt;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] fp_a = '0;
    logic [31:0] fp_b = '0;
    logic        out_valid, lt, nv;

    int checks = 0;
    int errors = 0;

    fp_flt dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .fp_a(fp_a), .fp_b(fp_b),
        .out_valid(out_valid), .lt(lt), .nv(nv)
    );

    always #5 clk = ~clk;

    // Reference: map each non-NaN value onto a signed integer line
    // (negatives mirrored, both zeros land on 0) and compare there.
    function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b);
        longint ka, kb;
        bit na, nb;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        if (na || nb) return 2'b01;
        ka = a[31] ? -longint'({33'b0, a[30:0]}) : longint'({33'b0, a[30:0]});
        kb = b[31] ? -longint'({33'b0, b[30:0]}) : longint'({33'b0, b[30:0]});
        return {(ka < kb), 1'b0};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0: v[30:0] = '0;
            1: v[30:23] = 8'hFF;
            2: v[30:0] = {8'hFF, 23'h0};
            3: v[30:23] = 8'h00;
            default: ;
        endcase
        return v;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic v);
        @(negedge clk);
        fp_a = a;
        fp_b = b;
        in_valid = v;
    endtask

    localparam int ND = 22;
    logic [31:0] da [ND] = '{32'h3F000000, 32'h3F800000, 32'hC2480000, 32'hC1000000,
                             32'hBF800000, 32'h3F800000, 32'h80000000, 32'h7F800000,
                             32'hFF800000, 32'h80000000, 32'h00000001, 32'h00000001,
                             32'h00080000, 32'h3F000000, 32'h7F7FFFFF, 32'hFF800000,
                             32'h7F800000, 32'h00800000, 32'h7FC00000, 32'h3F800000,
                             32'h7F800001, 32'h00000000};
    logic [31:0] db [ND] = '{32'h3F800000, 32'h3F000000, 32'hC1000000, 32'hC2480000,
                             32'h3F000000, 32'h3F800000, 32'h00000000, 32'h7F800000,
                             32'hFF800000, 32'h80800000, 32'h00000002, 32'h00080000,
                             32'h3F000000, 32'h00080000, 32'h7F800000, 32'h7F7FFFFF,
                             32'h00800000, 32'h00000000, 32'h3F800000, 32'h7FC00000,
                             32'h3F800000, 32'h80000000};
    logic [1:0]  de [ND] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00,
                             2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10,
                             2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};

    task automatic test_reset();
        drive(32'hBF800000, 32'h3F800000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, lt, nv} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: got {vld,lt,nv}=%b expected 000", {out_valid, lt, nv});
        end
        drive(32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, lt, nv} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: got {vld,lt,nv}=%b expected 000", {out_valid, lt, nv});
        end
    endtask

    task automatic test_directed();
        for (int i = 0; i < ND; i++) begin
            drive(da[i], db[i], 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, lt, nv} !== {1'b1, de[i]}) begin
                errors++;
                $display("FAIL directed[%0d] a=%h b=%h: got {vld,lt,nv}=%b expected %b",
                         i, da[i], db[i], {out_valid, lt, nv}, {1'b1, de[i]});
            end
        end
        drive(32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic [1:0]  exp_r;
        for (int i = 0; i < 300; i++) begin
            a = rand_fp();
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = {a[31], rand_fp() & 32'h7FFFFFFF};
                2: b = {~a[31], a[30:0]};
                default: b = rand_fp();
            endcase
            if ($urandom_range(0, 1) == 1) {a, b} = {b, a};
            exp_r = ref_cmp(a, b);
            drive(a, b, 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, lt, nv} !== {1'b1, exp_r}) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h: got {vld,lt,nv}=%b expected %b",
                         i, a, b, {out_valid, lt, nv}, {1'b1, exp_r});
            end
        end
        drive(32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] qa [4], qb [4];
        for (int i = 0; i < 4; i++) begin
            qa[i] = rand_fp();
            qb[i] = (i == 1) ? 32'h7FC00000 : rand_fp();
        end
        qa[0] = 32'h3F000000; qb[0] = 32'h3F800000;
        for (int i = 0; i < 4; i++) begin
            drive(qa[i], qb[i], 1'b1);
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, lt, nv} !== {1'b1, ref_cmp(qa[i], qb[i])}) begin
                errors++;
                $display("FAIL stream[%0d]: got {vld,lt,nv}=%b expected %b",
                         i, {out_valid, lt, nv}, {1'b1, ref_cmp(qa[i], qb[i])});
            end
        end
        drive(32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_hold();
        drive(32'hFF800000, 32'h7F7FFFFF, 1'b1);
        drive(32'h7FC00000, 32'h3F800000, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, lt, nv} !== 3'b010) begin
            errors++;
            $display("FAIL hold_lt: got {vld,lt,nv}=%b expected 010", {out_valid, lt, nv});
        end
        drive(32'h7F800001, 32'h3F800000, 1'b1);
        drive(32'h00000001, 32'h00000002, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, lt, nv} !== 3'b001) begin
            errors++;
            $display("FAIL hold_nv: got {vld,lt,nv}=%b expected 001", {out_valid, lt, nv});
        end
    endtask

    task automatic test_async_reset();
        drive(32'h00000001, 32'h00080000, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, lt, nv} !== 3'b110) begin
            errors++;
            $display("FAIL pre_reset: got {vld,lt,nv}=%b expected 110", {out_valid, lt, nv});
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, lt, nv} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: got {vld,lt,nv}=%b expected 000", {out_valid, lt, nv});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, lt, nv} !== 3'b000) begin
            errors++;
            $display("FAIL reset_held: got {vld,lt,nv}=%b expected 000", {out_valid, lt, nv});
        end
        drive(32'h00000001, 32'h00080000, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, lt, nv} !== 3'b000) begin
            errors++;
            $display("FAIL post_reset_idle: got {vld,lt,nv}=%b expected 000", {out_valid, lt, nv});
        end
        drive(32'hC2480000, 32'hC1000000, 1'b1);
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, lt, nv} !== 3'b110) begin
            errors++;
            $display("FAIL post_reset_valid: got {vld,lt,nv}=%b expected 110", {out_valid, lt, nv});
        end
        drive(32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_hold();
        test_async_reset();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
